// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions: register-index width, the R0/RNONE constants
// and the commit qualifier used by write-back and forwarding logic.
package wb_regfile_pkg;

  localparam int RIDX_W = 5;

  typedef logic [RIDX_W-1:0] ridx_t;

  localparam ridx_t R0    = '0;
  localparam ridx_t RNONE = '0;

  // A write-back only takes effect for a nonzero destination.
  function automatic logic is_commit(input logic regwr, input ridx_t rw);
    return regwr && (rw != R0);
  endfunction

endpackage

// File: rtl/wb_regfile_wb_mux.sv
// Write-back value select; also reused by the EX-stage forwarding path.
module wb_mux #(
  parameter int DW = 32
) (
  input  logic          i_sel,
  input  logic [DW-1:0] i_d1,
  input  logic [DW-1:0] i_d0,
  output logic [DW-1:0] o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/wb_regfile.sv
// 31-entry register file with write-back mux, optional same-cycle forwarding,
// a commit counter and a record of the most recent committed write.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DW     = 32,
  parameter int BYPASS = 1,
  parameter int CW     = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [DW-1:0]     Dataout,
  input  logic [DW-1:0]     ALUout,
  input  logic              MemtoReg,
  input  logic              RegWr,
  input  logic [RIDX_W-1:0] Rw,
  input  logic [RIDX_W-1:0] Ra,
  input  logic [RIDX_W-1:0] Rb,
  output logic [DW-1:0]     busA,
  output logic [DW-1:0]     busB,
  output logic [DW-1:0]     busW,
  output logic [CW-1:0]     wr_count,
  output logic [RIDX_W-1:0] last_rw,
  output logic [DW-1:0]     last_w
);

  logic [DW-1:0]     r_regs [1:31];
  logic [CW-1:0]     r_wr_count;
  logic [RIDX_W-1:0] r_last_rw;
  logic [DW-1:0]     r_last_w;
  logic [DW-1:0]     w_busW;
  logic [DW-1:0]     w_busA;
  logic [DW-1:0]     w_busB;
  logic              w_commit;

  wb_mux #(.DW(DW)) u_wb_mux (
    .i_sel (MemtoReg),
    .i_d1  (Dataout),
    .i_d0  (ALUout),
    .o_y   (w_busW)
  );

  assign w_commit = is_commit(RegWr, Rw);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 1; i < 32; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      r_regs[Rw] <= w_busW;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wr_count <= '0;
      r_last_rw  <= RNONE;
      r_last_w   <= '0;
    end else if (w_commit) begin
      r_wr_count <= r_wr_count + CW'(1);
      r_last_rw  <= Rw;
      r_last_w   <= w_busW;
    end
  end

  // The bypass term requires a commit, so it can never override index 0.
  always_comb begin
    w_busA = '0;
    w_busB = '0;
    if (Ra != R0) w_busA = r_regs[Ra];
    if (Rb != R0) w_busB = r_regs[Rb];
    if (BYPASS != 0 && w_commit) begin
      if (Rw == Ra) w_busA = w_busW;
      if (Rw == Rb) w_busB = w_busW;
    end
  end

  assign busA     = w_busA;
  assign busB     = w_busB;
  assign busW     = w_busW;
  assign wr_count = r_wr_count;
  assign last_rw  = r_last_rw;
  assign last_w   = r_last_w;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a forwarding instance (BYPASS=1, CW=16)
// and a non-forwarding instance (BYPASS=0, CW=4) driven by the same stimulus.
module tb_wb_regfile;

  logic        Clk;
  logic        Rst_n;
  logic [31:0] Dataout, ALUout;
  logic        MemtoReg, RegWr;
  logic [4:0]  Rw, Ra, Rb;

  logic [31:0] busA1, busB1, busW1, last_w1;
  logic [15:0] wr_count1;
  logic [4:0]  last_rw1;
  logic [31:0] busA0, busB0, busW0, last_w0;
  logic [3:0]  wr_count0;
  logic [4:0]  last_rw0;

  wb_regfile #(.DW(32), .BYPASS(1), .CW(16)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .Dataout(Dataout), .ALUout(ALUout),
    .MemtoReg(MemtoReg), .RegWr(RegWr), .Rw(Rw), .Ra(Ra), .Rb(Rb),
    .busA(busA1), .busB(busB1), .busW(busW1), .wr_count(wr_count1),
    .last_rw(last_rw1), .last_w(last_w1)
  );

  wb_regfile #(.DW(32), .BYPASS(0), .CW(4)) u_dut_nb (
    .Clk(Clk), .Rst_n(Rst_n), .Dataout(Dataout), .ALUout(ALUout),
    .MemtoReg(MemtoReg), .RegWr(RegWr), .Rw(Rw), .Ra(Ra), .Rb(Rb),
    .busA(busA0), .busB(busB0), .busW(busW0), .wr_count(wr_count0),
    .last_rw(last_rw0), .last_w(last_w0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Signal selectors: 0 busA,1 busB,2 busW,3 wr_count,4 last_rw,5 last_w,
  // 6 busA(nb),7 busB(nb),8 wr_count(nb)
  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } item_t;

  item_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic chk(input string nm, input int sig, input logic [31:0] v);
    item_t it;
    it.name = nm;
    it.sig  = sig;
    it.exp  = v;
    q.push_back(it);
  endtask

  function automatic logic [31:0] act(input int s);
    case (s)
      0: return busA1;
      1: return busB1;
      2: return busW1;
      3: return 32'(wr_count1);
      4: return 32'(last_rw1);
      5: return last_w1;
      6: return busA0;
      7: return busB0;
      8: return 32'(wr_count0);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  always @(negedge Clk) begin
    while (q.size() > 0) begin
      item_t it;
      logic [31:0] a;
      it = q.pop_front();
      a  = act(it.sig);
      n_tests++;
      if (a !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, a, it.exp);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [4:0] rw, input logic m2r,
                       input logic [31:0] dout, input logic [31:0] alu,
                       input logic [4:0] ra, input logic [4:0] rb);
    RegWr = wr; Rw = rw; MemtoReg = m2r; Dataout = dout; ALUout = alu;
    Ra = ra; Rb = rb;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst_n = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd6, 5'd31);
    #2 Rst_n = 1'b0;
    chk("rst_busA", 0, 32'h0);  chk("rst_busB", 1, 32'h0);
    chk("rst_cnt", 3, 32'h0);   chk("rst_last_rw", 4, 32'h0);
    chk("rst_last_w", 5, 32'h0); chk("rst_cnt_nb", 8, 32'h0);
    step();
    Rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
      chk("idle_busA", 0, 32'h0); chk("idle_busB", 1, 32'h0);
      chk("idle_busA_nb", 6, 32'h0);
      step();
    end
    chk("idle_cnt", 3, 32'h0); chk("idle_last_rw", 4, 32'h0);

    // r5 <= 0x1234 via ALUout
    drive(1'b1, 5'd5, 1'b0, 32'h0BAD_0BAD, 32'h0000_1234, 5'd5, 5'd0);
    chk("w5_busW", 2, 32'h1234); chk("w5_bypA", 0, 32'h1234);
    chk("w5_nbA", 6, 32'h0);     chk("w5_cnt_pre", 3, 32'h0);
    step();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd0);
    chk("r5_busA", 0, 32'h1234); chk("r5_nbA", 6, 32'h1234);
    chk("r5_cnt", 3, 32'd1);     chk("r5_last_rw", 4, 32'd5);
    chk("r5_last_w", 5, 32'h1234);
    step();

    // r7 <= 0xDEADBEEF via Dataout, read both ports same cycle
    drive(1'b1, 5'd7, 1'b1, 32'hDEAD_BEEF, 32'h0000_0055, 5'd7, 5'd7);
    chk("w7_busW", 2, 32'hDEAD_BEEF);
    chk("w7_bypA", 0, 32'hDEAD_BEEF); chk("w7_bypB", 1, 32'hDEAD_BEEF);
    chk("w7_nbA", 6, 32'h0);          chk("w7_nbB", 7, 32'h0);
    step();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd7);
    chk("r7_busA", 0, 32'hDEAD_BEEF); chk("r7_nbB", 7, 32'hDEAD_BEEF);
    chk("r7_cnt", 3, 32'd2);          chk("r7_last_rw", 4, 32'd7);
    chk("r7_last_w", 5, 32'hDEAD_BEEF);
    step();

    // write to r0 is ignored
    drive(1'b1, 5'd0, 1'b0, 32'h0, 32'h0000_FFFF, 5'd0, 5'd0);
    chk("w0_busA", 0, 32'h0); chk("w0_busB", 1, 32'h0);
    step();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7);
    chk("r0_busA", 0, 32'h0);  chk("r0_cnt", 3, 32'd2);
    chk("r0_last_rw", 4, 32'd7); chk("r0_last_w", 5, 32'hDEAD_BEEF);
    step();

    // back-to-back writes to r5
    drive(1'b1, 5'd5, 1'b0, 32'h0, 32'h0000_1111, 5'd5, 5'd0);
    step();
    drive(1'b1, 5'd5, 1'b0, 32'h0, 32'h0000_2222, 5'd5, 5'd0);
    chk("b2b_bypA", 0, 32'h2222); chk("b2b_nbA_old", 6, 32'h1111);
    step();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd0);
    chk("b2b_busA", 0, 32'h2222); chk("b2b_cnt", 3, 32'd4);
    chk("b2b_last_w", 5, 32'h2222);
    step();

    // held inputs for three cycles commit three times
    drive(1'b1, 5'd9, 1'b0, 32'h0, 32'h0000_0099, 5'd0, 5'd9);
    step(); step(); step();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9);
    chk("stall_busB", 1, 32'h99); chk("stall_cnt", 3, 32'd7);
    chk("stall_cnt_nb", 8, 32'd7);
    step();

    // nine more commits bring the 4-bit counter to 16 -> 0
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 5'(10 + i), 1'b0, 32'h0, 32'h100 + 32'(i), 5'd0, 5'd0);
      step();
    end
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd18, 5'd10);
    chk("wrap_busA", 0, 32'h108); chk("wrap_busB", 1, 32'h100);
    chk("wrap_cnt", 3, 32'd16);   chk("wrap_cnt_nb", 8, 32'd0);
    step();
    drive(1'b1, 5'd19, 1'b0, 32'h0, 32'h0000_0200, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd19, 5'd0);
    chk("wrap1_cnt", 3, 32'd17); chk("wrap1_cnt_nb", 8, 32'd1);
    chk("wrap1_busA", 0, 32'h200);
    step();

    // r3 <= 0xA5, then an asynchronous reset pulse
    drive(1'b1, 5'd3, 1'b0, 32'h0, 32'h0000_00A5, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd0);
    chk("r3_busA", 0, 32'hA5); chk("r3_cnt", 3, 32'd18);
    step();
    drive(1'b1, 5'd9, 1'b0, 32'h0, 32'h0000_0077, 5'd3, 5'd0);
    Rst_n = 1'b0;
    chk("arst_busA", 0, 32'h0);  chk("arst_nbA", 6, 32'h0);
    chk("arst_cnt", 3, 32'h0);   chk("arst_cnt_nb", 8, 32'h0);
    chk("arst_last_rw", 4, 32'h0); chk("arst_last_w", 5, 32'h0);
    step();
    Rst_n = 1'b1;
    drive(1'b1, 5'd4, 1'b0, 32'h0, 32'h0000_0044, 5'd9, 5'd3);
    chk("lost_busA", 0, 32'h0); chk("lost_busB", 1, 32'h0);
    chk("lost_cnt", 3, 32'h0);
    step();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd4, 5'd9);
    chk("post_busA", 0, 32'h44); chk("post_busB", 1, 32'h0);
    chk("post_cnt", 3, 32'd1);   chk("post_last_rw", 4, 32'd4);
    chk("post_last_w", 5, 32'h44);
    step();

    @(negedge Clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
